multi_flex_clk: RTL and testbench
=================================

# multi_flex_clk

Multi-channel, runtime-programmable clock divider and tick generator, the parametrised successor to the single-channel flex_clk divider. Each channel divides the 20 kHz system clock by a programmable limit, producing a square wave and a one-cycle tick. Per-channel enable, continuous or one-shot mode, and glitch-free limit reload applied only at a period boundary. Feeds display scan, debouncers and seconds counters from one shared block.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 21, counter and limit width in bits
- RESET_LIMIT, 9999, active and shadow limit of every channel after reset (1 Hz square wave at 20 kHz)
- SEL_W, $clog2(CHANNELS) (min 1), width of limit_sel
- clk_20k  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  CHANNELS  per-channel run enable
- mode  input  CHANNELS  per-channel mode: 0 continuous, 1 one-shot
- sync  input  1  phase-align strobe for all channels
- limit_wr  input  1  limit write strobe
- limit_sel  input  SEL_W  target channel of limit_wr
- limit_data  input  WIDTH  new limit value
- limit_pending  output  CHANNELS  shadow limit written but not yet active
- slowclk  output  CHANNELS  divided square wave
- tick  output  CHANNELS  one-cycle pulse per divided period
- done  output  CHANNELS  one-shot channel has finished

## Operation
- Per channel: count[WIDTH], act_lim, shd_lim, state in {IDLE, RUN, DONE}; all outputs registered.
- Reset (rst_n=0 at an edge): count=0, act_lim=shd_lim=RESET_LIMIT, state=IDLE, slowclk=0, tick=0, done=0, limit_pending=0.
- Priority per edge: rst_n > sync > state/counter update; limit_wr is processed alongside either.
- IDLE: count holds; tick=0; if limit_pending, act_lim<=shd_lim and pending clears. en=1 -> RUN.
- RUN: en=0 -> IDLE (count and slowclk hold). Otherwise, if count >= act_lim, this is a wrap: count<=0, tick<=1, slowclk toggles, pending shadow copies to act_lim. If not a wrap, count<=count+1 and tick<=0.
- Comparison is >=, so a limit lowered below the current count wraps on the next enabled cycle and never counts past WIDTH.
- One-shot (mode=1): the first wrap in RUN goes to DONE, with done<=1. In DONE, count=0, tick=0 and slowclk holds. en=0 -> IDLE with done<=0. The channel re-arms only via IDLE.
- mode is sampled each cycle in RUN. Changing it mid-period affects only the next wrap.
- limit_wr: shd_lim[limit_sel]<=limit_data and limit_pending[limit_sel]<=1.
  - Writing while already pending overwrites the shadow; last write wins.
  - limit_sel >= CHANNELS is ignored.
  - If a write and a wrap (or IDLE apply) hit the same channel in the same cycle, the pre-write shadow is applied and the new value stays pending.
- sync (all channels): count<=0, slowclk<=0, tick<=0, pending shadows applied, DONE->IDLE with done<=0; RUN and IDLE are kept. A same-cycle limit_wr follows the same pre-write rule.
- limit=0: wrap every enabled cycle, tick held high, slowclk toggles every cycle.

## Timing
- With limit L, en high continuously: tick period L+1 cycles; slowclk period 2(L+1) cycles, 50% duty.
- Latency: en rises at edge k with count=0 -> first count==L sampled at edge k+L -> tick=1 and slowclk toggled after edge k+L+1 (RUN entered at k, counts from k+1).
- limit_pending rises the cycle after limit_wr and falls the cycle after the apply edge.
- done rises together with the final tick of a one-shot.
- No combinational path from any input to any output.

## Test plan
- Reset then en[0]=1, defaults -> tick[0] every 10000 cycles, slowclk[0] period 20000; other channels idle at 0.
- limit_wr ch1=4 while ch1 RUN at count 2 with act_lim 9 -> ch1 finishes count to 9 with old limit, then tick period 5; limit_pending[1] high until that wrap.
- Ch2 count=7, write limit 3 while ch2 IDLE, then en -> applied in IDLE; first enabled cycle wraps (7>=3), tick next cycle.
- mode[3]=1, limit 2, en high -> exactly one tick 4 cycles after enable; done[3]=1 and holds. Drop en -> done=0; raise en -> one more tick.
- sync pulse with channels at arbitrary counts plus limit_wr ch0=1 in the same cycle -> all count=0, slowclk=0; ch0 keeps the old limit with pending=1 until its next wrap.
- limit 0 on ch0 -> tick held 1 and slowclk toggles each cycle. Assert rst_n=0 mid-run -> all outputs 0 and limits back to 9999 the next cycle.

Source files
------------

// File: rtl/multi_flex_clk.sv
// multi_flex_clk: multi-channel programmable clock divider / tick generator.
// Each channel divides clk_20k by (limit+1), producing a one-cycle tick per
// period and a 50% square wave toggling on every wrap. New limits land in a
// shadow register and only take effect at a period boundary (wrap), while the
// channel sits in IDLE, or on a sync strobe, so the outputs never glitch.
module multi_flex_clk #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 21,
  parameter int RESET_LIMIT = 9999,
  parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_20k,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] mode,
  input  logic                sync,
  input  logic                limit_wr,
  input  logic [SEL_W-1:0]    limit_sel,
  input  logic [WIDTH-1:0]    limit_data,
  output logic [CHANNELS-1:0] limit_pending,
  output logic [CHANNELS-1:0] slowclk,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(RESET_LIMIT);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;
    logic             wr_hit;
    logic             wrap;
    logic             apply;

    // Out-of-range selects never match any channel index, so they are dropped.
    assign wr_hit = limit_wr && (limit_sel == SEL_W'(g));
    // >= rather than == so a limit lowered below the count still wraps at once.
    assign wrap   = (state_q == S_RUN) && en[g] && (count_q >= act_q);

    // State register plus all per-channel registered outputs and limits.
    always_ff @(posedge clk_20k) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        count_q <= '0;
        act_q   <= LIM_RST;
        shd_q   <= LIM_RST;
        slow_q  <= 1'b0;
        tick_q  <= 1'b0;
        done_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        act_q   <= act_d;
        shd_q   <= shd_d;
        slow_q  <= slow_d;
        tick_q  <= tick_d;
        done_q  <= done_d;
        pend_q  <= pend_d;
      end
    end

    // Next-state: sync releases DONE, otherwise en/mode drive the transitions.
    always_comb begin
      state_d = state_q;
      if (sync) begin
        if (state_q == S_DONE) state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE:  if (en[g]) state_d = S_RUN;
          S_RUN: begin
            if (!en[g])               state_d = S_IDLE;
            else if (wrap && mode[g]) state_d = S_DONE;
          end
          S_DONE:  if (!en[g]) state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Counter, outputs and limit handling; a write alongside an apply stays
    // pending because the apply always copies the shadow as it was before it.
    always_comb begin
      count_d = count_q;
      slow_d  = slow_q;
      tick_d  = 1'b0;
      done_d  = done_q;
      apply   = 1'b0;
      if (sync) begin
        count_d = '0;
        slow_d  = 1'b0;
        done_d  = 1'b0;
        apply   = pend_q;
      end else begin
        unique case (state_q)
          S_IDLE: apply = pend_q;
          S_RUN: begin
            if (wrap) begin
              count_d = '0;
              tick_d  = 1'b1;
              slow_d  = ~slow_q;
              apply   = pend_q;
              if (mode[g]) done_d = 1'b1;
            end else if (en[g]) begin
              count_d = count_q + WIDTH'(1);
            end
          end
          S_DONE: begin
            count_d = '0;
            if (!en[g]) done_d = 1'b0;
          end
          default: count_d = '0;
        endcase
      end
      act_d  = apply ? shd_q : act_q;
      shd_d  = wr_hit ? limit_data : shd_q;
      pend_d = wr_hit ? 1'b1 : (apply ? 1'b0 : pend_q);
    end

    assign limit_pending[g] = pend_q;
    assign slowclk[g]       = slow_q;
    assign tick[g]          = tick_q;
    assign done[g]          = done_q;
  end

endmodule

// File: tb/tb_multi_flex_clk.sv
// tb_multi_flex_clk: table-driven vectors, directed multi-cycle sequences and
// randomized traffic, all cross-checked every cycle against a channel model.
module tb_multi_flex_clk;
  localparam int NCH = 4;
  localparam int W   = 21;

  logic           clk_20k = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en, mode;
  logic           sync, limit_wr;
  logic [1:0]     limit_sel;
  logic [W-1:0]   limit_data;
  logic [NCH-1:0] limit_pending, slowclk, tick, done;

  always #5 clk_20k = ~clk_20k;

  multi_flex_clk #(.CHANNELS(NCH), .WIDTH(W), .RESET_LIMIT(9999)) dut (
    .clk_20k(clk_20k), .rst_n(rst_n), .en(en), .mode(mode), .sync(sync),
    .limit_wr(limit_wr), .limit_sel(limit_sel), .limit_data(limit_data),
    .limit_pending(limit_pending), .slowclk(slowclk), .tick(tick), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one record per channel, stepped once per clock.
  int m_cnt[NCH], m_act[NCH], m_shd[NCH];
  bit m_run[NCH], m_fin[NCH], m_slow[NCH], m_tick[NCH], m_done[NCH], m_pend[NCH];

  typedef struct {
    logic         rst_n;
    logic [3:0]   en, mode;
    logic         sync, wr;
    logic [1:0]   sel;
    logic [W-1:0] data;
    logic [3:0]   e_tick, e_slow, e_done, e_pend;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] e, input logic [3:0] m,
                              input logic s, input logic w, input logic [1:0] sl,
                              input int d, input logic [3:0] et, input logic [3:0] es,
                              input logic [3:0] ed, input logic [3:0] ep);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.sync = s; v.wr = w; v.sel = sl;
    v.data = W'(d); v.e_tick = et; v.e_slow = es; v.e_done = ed; v.e_pend = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit hit, app;
      if (!rst_n) begin
        m_cnt[c] = 0; m_act[c] = 9999; m_shd[c] = 9999;
        m_run[c] = 0; m_fin[c] = 0; m_slow[c] = 0; m_tick[c] = 0;
        m_done[c] = 0; m_pend[c] = 0;
        continue;
      end
      hit = limit_wr && (int'(limit_sel) == c);
      app = 0;
      m_tick[c] = 0;
      if (sync) begin
        m_cnt[c] = 0; m_slow[c] = 0; app = m_pend[c];
        if (m_fin[c]) begin m_fin[c] = 0; m_done[c] = 0; end
      end else if (m_fin[c]) begin
        m_cnt[c] = 0;
        if (!en[c]) begin m_fin[c] = 0; m_done[c] = 0; end
      end else if (!m_run[c]) begin
        app = m_pend[c];
        if (en[c]) m_run[c] = 1;
      end else if (!en[c]) begin
        m_run[c] = 0;
      end else if (m_cnt[c] >= m_act[c]) begin
        m_cnt[c] = 0; m_tick[c] = 1; m_slow[c] = !m_slow[c]; app = m_pend[c];
        if (mode[c]) begin m_run[c] = 0; m_fin[c] = 1; m_done[c] = 1; end
      end else begin
        m_cnt[c]++;
      end
      if (app) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
      if (hit) begin m_shd[c] = int'(limit_data); m_pend[c] = 1; end
    end
  endtask

  function automatic logic [15:0] model_pack();
    logic [3:0] p, s, t, d;
    for (int c = 0; c < NCH; c++) begin
      p[c] = m_pend[c]; s[c] = m_slow[c]; t[c] = m_tick[c]; d[c] = m_done[c];
    end
    return {p, s, t, d};
  endfunction

  task automatic step();
    @(posedge clk_20k);
    model_step();
    @(negedge clk_20k);
    chk($sformatf("model@%0t", $time), {16'd0, limit_pending, slowclk, tick, done},
        {16'd0, model_pack()});
  endtask

  task automatic write_lim(input int sel, input int data);
    limit_wr = 1'b1; limit_sel = 2'(sel); limit_data = W'(data);
    step();
    limit_wr = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < max);
  endtask

  initial begin
    int n, acc;
    logic prev;
    rst_n = 1'b0; en = '0; mode = '0; sync = 1'b0;
    limit_wr = 1'b0; limit_sel = '0; limit_data = '0;
    step();
    step();

    // rst, en, mode, sync, wr, sel, data -> tick, slow, done, pend
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(1, 4'h0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; mode = tbl[i].mode; sync = tbl[i].sync;
      limit_wr = tbl[i].wr; limit_sel = tbl[i].sel; limit_data = tbl[i].data;
      step();
      chk($sformatf("tbl%0d", i), {16'd0, limit_pending, slowclk, tick, done},
          {16'd0, tbl[i].e_pend, tbl[i].e_slow, tbl[i].e_tick, tbl[i].e_done});
    end
    rst_n = 1'b1; limit_wr = 1'b0; sync = 1'b0; mode = '0;

    // Default limit 9999 on ch0 after reset
    en = 4'b0001;
    wait_tick(0, 10100, n);
    chk("def_first_tick", n, 10001);
    chk("def_slow_hi", 32'(slowclk[0]), 1);
    wait_tick(0, 10100, n);
    chk("def_period", n, 10000);
    chk("def_slow_lo", 32'(slowclk[0]), 0);

    // ch1: reload mid-period finishes old limit first
    write_lim(1, 9);
    step();
    chk("ch1_applied_idle", 32'(limit_pending[1]), 0);
    en[1] = 1'b1;
    step(); step(); step();
    write_lim(1, 4);
    chk("ch1_pending", 32'(limit_pending[1]), 1);
    wait_tick(1, 20, n);
    chk("ch1_old_wrap", n, 7);
    chk("ch1_pend_clear", 32'(limit_pending[1]), 0);
    wait_tick(1, 20, n);
    chk("ch1_new_period", n, 5);

    // ch2: lowered limit applied in IDLE wraps on first enabled cycle
    write_lim(2, 20);
    step();
    en[2] = 1'b1;
    repeat (8) step();
    en[2] = 1'b0;
    step();
    write_lim(2, 3);
    chk("ch2_pending", 32'(limit_pending[2]), 1);
    step();
    chk("ch2_idle_apply", 32'(limit_pending[2]), 0);
    en[2] = 1'b1;
    wait_tick(2, 20, n);
    chk("ch2_first_wrap", n, 2);

    // ch3: one-shot
    write_lim(3, 2);
    step();
    en[3] = 1'b1; mode[3] = 1'b1;
    wait_tick(3, 20, n);
    chk("os_tick", n, 4);
    chk("os_done", 32'(done[3]), 1);
    acc = 0;
    repeat (6) begin step(); acc += int'(tick[3]); end
    chk("os_no_more_ticks", acc, 0);
    chk("os_done_hold", 32'(done[3]), 1);
    en[3] = 1'b0;
    step();
    chk("os_done_clear", 32'(done[3]), 0);
    en[3] = 1'b1;
    wait_tick(3, 20, n);
    chk("os_rearm_tick", n, 4);
    en[3] = 1'b0; mode[3] = 1'b0;
    step();

    // sync with a same-cycle write to ch0
    sync = 1'b1;
    write_lim(0, 1);
    sync = 1'b0;
    chk("sync_slow", 32'(slowclk), 0);
    chk("sync_pend0", 32'(limit_pending[0]), 1);
    wait_tick(0, 10100, n);
    chk("sync_old_lim", n, 10000);
    chk("sync_pend0_clear", 32'(limit_pending[0]), 0);
    wait_tick(0, 20, n);
    chk("sync_new_lim", n, 2);

    // limit 0 on ch0, then reset mid-run
    write_lim(0, 0);
    wait_tick(0, 5, n);
    chk("lim0_apply", n, 1);
    for (int k = 0; k < 6; k++) begin
      prev = slowclk[0];
      step();
      chk($sformatf("lim0_tick%0d", k), 32'(tick[0]), 1);
      chk($sformatf("lim0_slow%0d", k), 32'(slowclk[0]), 32'(!prev));
    end
    rst_n = 1'b0;
    step();
    chk("rst_outputs", {16'd0, limit_pending, slowclk, tick, done}, 0);
    rst_n = 1'b1; en = '0;
    step();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        en[c] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) mode[c] = ~mode[c];
      end
      sync       = ($urandom_range(0, 49) == 0);
      limit_wr   = ($urandom_range(0, 7) == 0);
      limit_sel  = 2'($urandom_range(0, 3));
      limit_data = W'($urandom_range(0, 12));
      rst_n      = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
